// File: rtl/seven_seg_to_val.sv
// Readback decoder for a multiplexed active-low seven-segment display: waits for each
// digit's pattern to be stable, decodes it to a value and reports complete frames.
module seven_seg_to_val #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_DIGITS-1:0]     anodes,
    input  logic [6:0]                display_segs,
    output logic [4*NUM_DIGITS-1:0]   values,
    output logic [NUM_DIGITS-1:0]     digit_err,
    output logic                      frame_strobe,
    output logic                      frame_ok,
    output logic                      err_sticky
);

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    typedef enum logic {COLLECT, DONE} frame_state_t;

    frame_state_t            state, state_next;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic [3:0]              cnt, cnt_next;
    logic [NUM_DIGITS-1:0]   seen, seen_next;
    logic [3:0]              low_cnt;
    logic                    one_hot, multi, same, commit;
    logic [NUM_DIGITS-1:0]   commit_bits;
    logic [NUM_DIGITS-1:0]   digit_err_next;
    logic                    frame_ok_next;
    logic [4:0]              dec;

    // Returns {illegal, value}; anything outside the ten glyphs is illegal and reads as F.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1111000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0010000: decode = 5'h09;
            default:    decode = 5'h1F;
        endcase
    endfunction

    assign dec = decode(display_segs);

    // The counter tracks the run length of the sample being loaded into the input
    // register, so the STABLE_CNT-th identical sample commits on its own load edge.
    always_comb begin
        low_cnt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            low_cnt = low_cnt + {3'b000, ~anodes[i]};
        end
        one_hot = (low_cnt == 4'd1);
        multi   = (low_cnt > 4'd1);
        same    = ({anodes, display_segs} == {an_q, seg_q});
        if (!one_hot) begin
            cnt_next = '0;
        end else if (same) begin
            cnt_next = (cnt == STABLE) ? cnt : cnt + 4'd1;
        end else begin
            cnt_next = 4'd1;
        end
        commit      = one_hot && same && (cnt == STABLE - 4'd1);
        commit_bits = commit ? ~anodes : '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_err_next[i] = commit_bits[i] ? dec[4] : digit_err[i];
        end
    end

    always_comb begin
        state_next    = state;
        seen_next     = seen;
        frame_ok_next = frame_ok;
        case (state)
            COLLECT: begin
                if ((seen | commit_bits) == {NUM_DIGITS{1'b1}}) begin
                    state_next    = DONE;
                    seen_next     = '0;
                    frame_ok_next = ~|digit_err_next;
                end else begin
                    seen_next = seen | commit_bits;
                end
            end
            DONE: begin
                state_next = COLLECT;
                seen_next  = commit_bits;
            end
            default: state_next = COLLECT;
        endcase
    end

    assign frame_strobe = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            an_q       <= '1;
            seg_q      <= 7'b1111111;
            cnt        <= '0;
            seen       <= '0;
            values     <= '1;
            digit_err  <= '0;
            frame_ok   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_next;
            an_q       <= anodes;
            seg_q      <= display_segs;
            cnt        <= cnt_next;
            seen       <= seen_next;
            digit_err  <= digit_err_next;
            frame_ok   <= frame_ok_next;
            err_sticky <= err_sticky | multi | (commit & dec[4]);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (commit_bits[i]) values[4*i +: 4] <= dec[3:0];
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_to_val.sv
// Randomized and directed bench for seven_seg_to_val against a sample-history model.
module tb_seven_seg_to_val;

    localparam int N = 4;
    localparam int S = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     anodes = '1;
    logic [6:0]       display_segs = 7'b1111111;
    logic [4*N-1:0]   values;
    logic [N-1:0]     digit_err;
    logic             frame_strobe, frame_ok, err_sticky;

    seven_seg_to_val #(.NUM_DIGITS(N), .STABLE_CNT(S)) dut (
        .clk(clk), .rst(rst), .anodes(anodes), .display_segs(display_segs),
        .values(values), .digit_err(digit_err), .frame_strobe(frame_strobe),
        .frame_ok(frame_ok), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int n_checks = 0;
    int n_fail = 0;
    int strobes = 0;
    logic last_ok = 1'b0;

    // Model state: a history of identical consecutive valid samples.
    logic [N+6:0]   hist_q [$];
    logic [4*N-1:0] m_values;
    logic [N-1:0]   m_err, m_seen;
    logic           m_strobe, m_ok, m_sticky;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist_q.delete();
        m_values = '1;
        m_err = '0;
        m_seen = '0;
        m_strobe = 0;
        m_ok = 0;
        m_sticky = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] an, input logic [6:0] seg);
        int lows = 0;
        int idx = 0;
        logic [N-1:0] cbit = '0;
        logic [N-1:0] tmp;
        for (int i = 0; i < N; i++) if (!an[i]) begin lows++; idx = i; end
        if (lows != 1) begin
            hist_q.delete();
            if (lows > 1) m_sticky = 1;
        end else begin
            if (hist_q.size() > 0 && hist_q[$] != {an, seg}) hist_q.delete();
            if (hist_q.size() <= S) begin
                hist_q.push_back({an, seg});
                if (hist_q.size() == S) begin
                    int v = 15;
                    for (int k = 0; k < 10; k++) if (glyph[k] == seg) v = k;
                    m_values[4*idx +: 4] = 4'(v);
                    m_err[idx] = (v == 15);
                    if (v == 15) m_sticky = 1;
                    cbit[idx] = 1'b1;
                end
            end
        end
        if (m_strobe) begin
            m_strobe = 0;
            m_seen = cbit;
        end else begin
            tmp = m_seen | cbit;
            if (tmp == '1) begin
                m_strobe = 1;
                m_ok = (m_err == '0);
                m_seen = '0;
            end else begin
                m_seen = tmp;
            end
        end
    endtask

    task automatic compare_all();
        check("values", 32'(values), 32'(m_values));
        check("digit_err", 32'(digit_err), 32'(m_err));
        check("frame_strobe", 32'(frame_strobe), 32'(m_strobe));
        check("frame_ok", 32'(frame_ok), 32'(m_ok));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        if (frame_strobe) begin
            strobes++;
            last_ok = frame_ok;
        end
    endtask

    // Inputs change at the falling edge; outputs are compared at the next falling edge.
    task automatic step(input logic [N-1:0] an, input logic [6:0] seg);
        anodes = an;
        display_segs = seg;
        @(posedge clk);
        model_edge(an, seg);
        @(negedge clk);
        compare_all();
    endtask

    task automatic dwell(input int d, input logic [6:0] seg, input int n);
        logic [N-1:0] an;
        an = '1;
        an[d] = 1'b0;
        for (int c = 0; c < n; c++) step(an, seg);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        anodes = '1;
        display_segs = 7'b1111111;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_values", 32'(values), 32'hFFFF);

        // Latency: commit after the 4th edge, not the 3rd.
        dwell(0, glyph[2], 3);
        check("early_commit", 32'(values), 32'hFFFF);
        dwell(0, glyph[2], 1);
        check("commit_d0", 32'(values), 32'hFFF2);
        check("commit_err", 32'(digit_err), 32'h0);

        // Full scan 1,2,3,4.
        do_reset();
        strobes = 0;
        for (int d = 0; d < N; d++) dwell(d, glyph[d+1], 6);
        dwell(0, glyph[1], 2);
        check("scan_strobes", strobes, 1);
        check("scan_ok", 32'(last_ok), 32'h1);
        check("scan_values", 32'(values), 32'h4321);

        // Short dwell on digit 2 does not commit.
        do_reset();
        strobes = 0;
        dwell(0, glyph[5], 6);
        dwell(1, glyph[6], 6);
        dwell(2, glyph[7], 3);
        dwell(3, glyph[8], 6);
        check("short_no_strobe", strobes, 0);
        dwell(2, glyph[7], 5);
        check("short_then_strobe", strobes, 1);
        check("short_values", 32'(values), 32'h8765);

        // Blank glyph on digit 1.
        strobes = 0;
        dwell(0, glyph[9], 6);
        dwell(1, 7'b1111111, 5);
        dwell(2, glyph[0], 6);
        dwell(3, glyph[3], 6);
        check("blank_strobes", strobes, 1);
        check("blank_ok", 32'(last_ok), 32'h0);
        check("blank_values", 32'(values[7:4]), 32'hF);
        check("blank_sticky", 32'(err_sticky), 32'h1);

        // Two anodes low, then a legal scan.
        do_reset();
        strobes = 0;
        for (int c = 0; c < 5; c++) step(4'b1100, glyph[4]);
        check("multi_sticky", 32'(err_sticky), 32'h1);
        check("multi_values", 32'(values), 32'hFFFF);
        for (int d = 0; d < N; d++) dwell(d, glyph[d], 6);
        step('1, 7'b1111111);
        check("multi_strobes", strobes, 1);
        check("multi_ok", 32'(last_ok), 32'h1);

        // Reset mid-frame discards partial progress.
        strobes = 0;
        dwell(0, glyph[1], 5);
        dwell(1, glyph[1], 5);
        do_reset();
        check("midrst_values", 32'(values), 32'hFFFF);
        check("midrst_sticky", 32'(err_sticky), 32'h0);
        dwell(2, glyph[2], 5);
        dwell(3, glyph[3], 5);
        check("midrst_no_strobe", strobes, 0);
        for (int d = 0; d < N; d++) dwell(d, glyph[9-d], 5);
        step('1, 7'b1111111);
        check("midrst_strobe", strobes, 1);

        // Randomized traffic.
        for (int it = 0; it < 150; it++) begin
            int kind = $urandom_range(0, 11);
            if (kind == 0) begin
                for (int c = 0; c < int'($urandom_range(1, 3)); c++) step('1, 7'($urandom));
            end else if (kind == 1) begin
                int a = $urandom_range(0, N-1);
                int b = (a + $urandom_range(1, N-1)) % N;
                logic [N-1:0] an = '1;
                an[a] = 1'b0;
                an[b] = 1'b0;
                for (int c = 0; c < int'($urandom_range(1, 5)); c++) step(an, 7'($urandom));
            end else if (kind == 2 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                int g = $urandom_range(0, 11);
                logic [6:0] seg;
                seg = (g < 10) ? glyph[g] : (g == 10) ? 7'b1111111 : 7'($urandom);
                dwell($urandom_range(0, N-1), seg, $urandom_range(1, 7));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
